// File: rtl/dct_sched_pkg.sv
// dct_sched_pkg: shared definitions for the 8-point transform sequencer.
//   - sched_state_t : sequencer FSM encoding
//   - DCT_N         : points per vector / basis rows
//   - CFG_*_W       : coefficient address field widths ({k, n})
//   - coef_default(): default DCT-II table entry in Q16.16, indexed {k, n}
package dct_sched_pkg;

    localparam int DCT_N      = 8;
    localparam int CFG_K_W    = 3;
    localparam int CFG_N_W    = 3;
    localparam int CFG_ADDR_W = CFG_K_W + CFG_N_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } sched_state_t;

    // Row 0 scale sqrt(1/8) in Q16.16.
    localparam logic [31:0] COEF_A0 = 32'h0000_5A82;

    // 0.5*cos(m*pi/16) in Q16.16 for m = 0..8. Every other table entry is
    // one of these magnitudes with a sign, so rows come out exactly
    // symmetric/antisymmetric.
    function automatic logic [31:0] cos_mag(input int m);
        case (m)
            0:       return 32'h0000_8000;
            1:       return 32'h0000_7D8A;
            2:       return 32'h0000_7642;
            3:       return 32'h0000_6A6E;
            4:       return 32'h0000_5A82;
            5:       return 32'h0000_471D;
            6:       return 32'h0000_30FC;
            7:       return 32'h0000_18F9;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // c[k][n] = a_k*cos((2n+1)k*pi/16); the angle is folded into the
    // first quadrant and the sign applied afterwards.
    function automatic logic [31:0] coef_default(input logic [CFG_ADDR_W-1:0] idx);
        int k;
        int n;
        int m;
        k = int'(idx[CFG_ADDR_W-1:CFG_N_W]);
        n = int'(idx[CFG_N_W-1:0]);
        if (k == 0) begin
            return COEF_A0;
        end
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) begin
            m = 32 - m;
        end
        if (m > 8) begin
            return 32'd0 - cos_mag(16 - m);
        end
        return cos_mag(m);
    endfunction

endpackage

// File: rtl/dct_coef_ram.sv
// dct_coef_ram: 64-entry coefficient register file for the transform.
//   clk, reset : clock and synchronous active-high reset (reloads defaults)
//   we, addr, wdata : single write port, addr = {k, n}
//   row_sel    : basis row k to read
//   row_data   : coefficient n of row k at [n*DATA_WIDTH +: DATA_WIDTH]
module dct_coef_ram
    import dct_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [CFG_ADDR_W-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [CFG_K_W-1:0]          row_sel,
    output logic [DATA_WIDTH*DCT_N-1:0] row_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DCT_N*DCT_N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DCT_N * DCT_N; i++) begin
                mem_reg[i] <= DATA_WIDTH'(coef_default(CFG_ADDR_W'(i)));
            end
        end else if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    // Whole row is read combinationally so a new row is available every
    // issue cycle without a read-latency bubble.
    generate
        for (genvar gi = 0; gi < DCT_N; gi++) begin : g_row
            assign row_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                mem_reg[{row_sel, CFG_N_W'(gi)}];
        end
    endgenerate

endmodule

// File: rtl/dct_8pt_sched.sv
// dct_8pt_sched: sequences one 8-wide multiply-add unit through the eight
// basis rows of an 8-point transform and collects the results.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : input vector handshake (sample n at n*W)
//   out_valid/out_ready/out_data : result vector handshake (X[k] at k*W)
//   mac_data, mac_coeff, mac_issue : operands/strobe to the multiply-add unit
//   mac_result            : registered sum returned one cycle after issue
//   cfg_we/cfg_addr/cfg_wdata : coefficient write, accepted only when idle
//   cfg_busy              : high whenever the sequencer is not idle
module dct_8pt_sched
    import dct_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] out_data,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] mac_data,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] mac_coeff,
    input  logic [DATA_WIDTH-1:0]            mac_result,
    output logic                             mac_issue,
    input  logic                             cfg_we,
    input  logic [CFG_ADDR_W-1:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0]            cfg_wdata,
    output logic                             cfg_busy
);

    sched_state_t                      state_reg;
    logic [CFG_K_W-1:0]                k_reg;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]  sample_reg;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]  result_reg;
    logic                              out_valid_reg;
    logic                              mac_issue_reg;
    logic                              cfg_busy_reg;
    logic                              coef_we;

    // Writes are only honoured in IDLE; a write coinciding with an accept
    // lands at that same edge, before the first row is read.
    assign coef_we = cfg_we && (state_reg == ST_IDLE);

    dct_coef_ram #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_coef_ram (
        .clk      (clk),
        .reset    (reset),
        .we       (coef_we),
        .addr     (cfg_addr),
        .wdata    (cfg_wdata),
        .row_sel  (k_reg),
        .row_data (mac_coeff)
    );

    // k returns to 0 on leaving ISSUE, so mac_coeff shows row 0 while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            sample_reg    <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            mac_issue_reg <= 1'b0;
            cfg_busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        sample_reg    <= in_data;
                        k_reg         <= '0;
                        mac_issue_reg <= 1'b1;
                        cfg_busy_reg  <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // mac_result lags issue by one cycle: it carries row k-1.
                    for (int i = 0; i < DATA_DEPTH - 1; i++) begin
                        if (k_reg == CFG_K_W'(i + 1)) begin
                            result_reg[i*DATA_WIDTH +: DATA_WIDTH] <= mac_result;
                        end
                    end
                    if (k_reg == CFG_K_W'(DATA_DEPTH - 1)) begin
                        k_reg         <= '0;
                        mac_issue_reg <= 1'b0;
                        state_reg     <= ST_DRAIN;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    result_reg[(DATA_DEPTH-1)*DATA_WIDTH +: DATA_WIDTH] <= mac_result;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        cfg_busy_reg  <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = result_reg;
    assign mac_data  = sample_reg;
    assign mac_issue = mac_issue_reg;
    assign cfg_busy  = cfg_busy_reg;

endmodule

// File: doc/dct_8pt_sched.md
Name: dct_8pt_sched

Overview:
- Sequencer for one shared 8-input Q16.16 multiply-add unit (8 multipliers plus an adder tree, one registered output, 1-cycle latency).
- Accepts one 8-sample vector over a valid/ready handshake and issues 8 dot products, one per DCT basis row k=0..7.
- Collects the 8 results and presents them as one output vector.
- Owns a writable 8x8 coefficient table, so the same unit can run DCT-II or other 8-point transforms.

Parameters:
DATA_WIDTH, 32, sample/coefficient/result width (Q16.16 signed)
DATA_DEPTH, 8, points per vector and number of basis rows; fixed at 8

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in_data  input  DATA_WIDTH*DATA_DEPTH  samples; sample n at [n*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  result vector valid
out_ready  input  1  downstream accepts the result
out_data  output  DATA_WIDTH*DATA_DEPTH  results; X[k] at [k*DATA_WIDTH +: DATA_WIDTH]
mac_data  output  DATA_WIDTH*DATA_DEPTH  data bus to the multiply-add unit
mac_coeff  output  DATA_WIDTH*DATA_DEPTH  coefficient row k to the multiply-add unit
mac_result  input  DATA_WIDTH  registered sum from the multiply-add unit
mac_issue  output  1  high in cycles where mac_data/mac_coeff carry a live row
cfg_we  input  1  coefficient write strobe
cfg_addr  input  6  {k[2:0], n[2:0]}
cfg_wdata  input  DATA_WIDTH  coefficient value
cfg_busy  output  1  high when not IDLE; writes are ignored

Behaviour:
- States: IDLE, ISSUE, DRAIN, OUT.
- Reset (sync, high): state=IDLE, k=0, in_ready=1 (it is combinational (state==IDLE)), out_valid=0, out_data=0, mac_data=0, mac_issue=0, cfg_busy=0. The coefficient table reloads the default DCT-II table.
- Default table: c[k][n] = a_k*cos((2n+1)kπ/16), with a0=sqrt(1/8) and ak=1/2, rounded to Q16.16. Examples: c[0][*]=0x00005A82, c[1][0]=0x00007D8A. The table must be exactly symmetric/antisymmetric per row.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the sample register, set k=0, go to ISSUE.
  - A cfg_we in IDLE writes table[cfg_addr] at the edge. If cfg_we and in_valid occur in the same cycle, the write lands first; the new value is used by the accepted vector.
- ISSUE (8 cycles):
  - mac_data = latched samples; mac_coeff = table row k; mac_issue=1.
  - From the 2nd ISSUE cycle on, mac_result holds row k-1; capture it into result slot k-1.
  - When k=7, go to DRAIN; otherwise k++.
- DRAIN (1 cycle): mac_issue=0; capture mac_result into slot 7; go to OUT.
- OUT:
  - out_valid=1 and out_data is stable until out_ready.
  - On out_ready: clear out_valid and go to IDLE.
  - No new input is accepted until back in IDLE.
- Latency: for an accept at edge E0, out_valid rises at edge E0+9. With out_ready held high, in_ready returns 1 cycle after out_valid, so the throughput is 1 vector per 11 cycles.
- cfg_we outside IDLE: ignored (no table change).
- Arithmetic: the block does no arithmetic. Results are passed through unmodified (wrap/truncation comes from the multiply-add unit).
- Reset in any state: abort immediately to IDLE, discard partial results, out_valid=0 the next cycle, and reload the table.
- mac_coeff is don't-care when mac_issue=0; it is driven with row 0.

Decomposition:
- Shared package/header dct_sched_pkg holds:
  - the state encodings;
  - DCT_N=8;
  - the default 64-entry Q16.16 DCT-II coefficient constants;
  - the cfg address field widths.
- One sub-module, dct_coef_ram:
  - 64xDATA_WIDTH register file with reset-loaded defaults, one write port, and a combinational 8-wide row read by k.

Test Plan:
- After reset, in_data = all samples 0x00010000 -> out_data X[0]=0x0002D410 and X[1..7]=0, out_valid at E0+9, mac_issue high exactly 8 cycles.
- Impulse, sample0=0x00010000 and others 0 -> X[k]=c[k][0], e.g. X[0]=0x00005A82 and X[1]=0x00007D8A.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, a second in_valid not accepted; release -> next vector accepted 1 cycle later.
- In IDLE write cfg_addr=0x00 with 0x00020000, then send the all-ones vector -> X[0]=0x0002D410+0x00020000-0x00005A82. A write issued in ISSUE leaves the table unchanged.
- Assert reset mid-ISSUE (k=4) -> next cycle IDLE, out_valid=0, table restored to defaults. A following vector produces the correct defaults-based result.
- Back-to-back vectors with out_ready=1 and random samples -> every result matches a reference model; accepts exactly 11 cycles apart.
